uart_rx_byte: RTL
=================

// Module: uart_rx_byte
//
// PURPOSE
// - Serial receive front end for the console input port.
// - Deserialises an 8N1 asynchronous line into one byte per frame.
// - Drives the input-port register directly: presents the byte on data and
//   pulses WE (active low) for one clk so the register captures it.
// - Sits immediately upstream of the register; its outputs connect to the
//   register's data/WE pins with no glue logic.
//
// PARAMETERS
// - WordSize    8   data bits per frame, LSB first; must match downstream register
// - ClksPerBit  16  clk cycles per serial bit; even, >= 4
//
// PORTS
// - clk          in   1         single system clock, rising edge
// - reset        in   1         asynchronous, active-high reset
// - rxd          in   1         raw serial line, idle high, asynchronous to clk
// - data         out  WordSize  last received byte, held until next good frame
// - WE           out  1         active-low write strobe to register, 1 clk wide
// - busy         out  1         high from start detect until frame end/abort
// - framing_err  out  1         1-clk high pulse when stop bit sampled low
//
// BEHAVIOUR
// - Reset (async, any state):
//   - state=IDLE, data=0, WE=1, busy=0, framing_err=0
//   - counters=0, synchroniser flops=1 (line idle)
// - rxd passes a 2-flop synchroniser -> rx_s; all decisions use rx_s only.
// - States: IDLE, START, DATA, STOP, BREAK.
//   - IDLE: rx_s==0 -> START, clear tick/bit counters, busy=1 (start-detect edge = t0).
//   - START: at t0+ClksPerBit/2-1 sample rx_s.
//     - 1 -> glitch, back to IDLE, busy=0, no pulses.
//     - 0 -> DATA.
//   - DATA: bit k (k=0..WordSize-1) sampled at t0+ClksPerBit/2-1+(k+1)*ClksPerBit,
//     shifted in LSB first; after bit WordSize-1 -> STOP.
//   - STOP: sample at t0+ClksPerBit/2-1+(WordSize+1)*ClksPerBit.
//     - 1 -> next edge: data<=shift reg, WE=0 for exactly that cycle, busy=0, -> IDLE.
//     - 0 -> next edge: framing_err=1 one cycle, data unchanged, WE stays 1, -> BREAK.
//   - BREAK: wait until rx_s==1, then -> IDLE (busy=0 on that edge).
//     No start detect while line is held low.
// - Latency (defaults): WE low in cycle t0+152, busy falls same edge;
//   back-to-back frames accepted: IDLE re-arms in that cycle.
// - data changes only on the edge that asserts WE; stable all other cycles.
// - WE and framing_err are never active in the same cycle.
// - Tick counter width = clog2(ClksPerBit); bit counter width = clog2(WordSize+1);
//   both wrap/clear on state change only.
// - Reset mid-frame: partial byte discarded, no WE, outputs as reset values.
//
// STRUCTURE
// - Shared package: state encoding constants (IDLE..BREAK), default
//   ClksPerBit for the console baud rate.
// - One sub-module: sync2 (2-flop synchroniser, async reset to 1).
// - FSM, counters, shift register in this module.
//
// TESTING
// - Reset: assert reset mid-frame -> WE=1, data=0, busy=0 immediately;
//   next full frame 0x5A received normally.
// - Good frame 0xA5, ClksPerBit=16 -> WE low exactly one cycle at t0+152,
//   data=0xA5, framing_err never high.
// - Glitch: rxd low 5 clks then high -> no WE, busy returns 0 by t0+8,
//   state IDLE.
// - Bad stop bit (frame 0x3C, stop=0) -> framing_err one-cycle pulse,
//   data keeps prior value, WE stays 1; no new frame until rxd high.
// - Back-to-back frames 0x00, 0xFF, 0x81, zero idle between -> three WE
//   pulses 160 clks apart, data sequence exact.
// - Downstream check: uart_rx_byte feeding register -> register output
//   equals each received byte one clk after its WE pulse.

Source files
------------

// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the console UART receiver: state encoding and console defaults.
package uart_rx_byte_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    localparam int CONSOLE_CLKS_PER_BIT = 16;
    localparam int CONSOLE_WORD_SIZE    = 8;

endpackage

// File: rtl/uart_rx_byte_sync2.sv
// Two-flop synchroniser for the raw serial line; resets to the idle (high) level.
module uart_rx_byte_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 receiver driving an input-port register: data plus a one-clk active-low WE.
// state | meaning
// IDLE  | line idle, waiting for a low level
// START | mid-start-bit check, rejects glitches
// DATA  | sampling data bits LSB first
// STOP  | sampling stop bit, then commit or flag framing error
// BREAK | line held low after bad stop, waiting for it to return high
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int WordSize   = CONSOLE_WORD_SIZE,
    parameter int ClksPerBit = CONSOLE_CLKS_PER_BIT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rxd,
    output logic [WordSize-1:0] data,
    output logic                WE,
    output logic                busy,
    output logic                framing_err
);

    localparam int TW = $clog2(ClksPerBit);
    localparam int BW = $clog2(WordSize + 1);
    localparam logic [TW-1:0] HALF_TC  = TW'(ClksPerBit / 2 - 2);
    localparam logic [TW-1:0] BIT_TC   = TW'(ClksPerBit - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WordSize - 1);

    rx_state_t           state, state_nxt;
    logic                rx_s;
    logic [TW-1:0]       tick;
    logic [BW-1:0]       bit_cnt;
    logic [WordSize-1:0] shift;
    logic                stop_seen, stop_bit;
    logic                commit, we_nxt, ferr_nxt;

    uart_rx_byte_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!rx_s) state_nxt = ST_START;
            ST_START: if (tick == HALF_TC) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (tick == BIT_TC && bit_cnt == LAST_BIT) state_nxt = ST_STOP;
            ST_STOP:  if (stop_seen) state_nxt = stop_bit ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx_s) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Counters restart on every state change, so each state times from its own entry edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick      <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            stop_seen <= 1'b0;
            stop_bit  <= 1'b1;
        end else begin
            if (state_nxt != state) begin
                tick    <= '0;
                bit_cnt <= '0;
            end else begin
                tick <= (tick == BIT_TC) ? '0 : tick + 1'b1;
                if (state == ST_DATA && tick == BIT_TC) bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == ST_DATA && tick == BIT_TC) shift <= {rx_s, shift[WordSize-1:1]};
            if (state == ST_STOP && tick == BIT_TC && !stop_seen) begin
                stop_seen <= 1'b1;
                stop_bit  <= rx_s;
            end else if (state != ST_STOP) begin
                stop_seen <= 1'b0;
            end
        end
    end

    always_comb begin
        commit   = 1'b0;
        we_nxt   = 1'b1;
        ferr_nxt = 1'b0;
        if (state == ST_STOP && stop_seen) begin
            if (stop_bit) begin
                commit = 1'b1;
                we_nxt = 1'b0;
            end else begin
                ferr_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data        <= '0;
            WE          <= 1'b1;
            framing_err <= 1'b0;
        end else begin
            WE          <= we_nxt;
            framing_err <= ferr_nxt;
            if (commit) data <= shift;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
